raifes_md_issue: RTL and testbench

- Requester-side controller for the multiply/divide unit; sits between the execute stage and the MD responder.
- Latches a decoded MUL/DIV/REM instruction from execute and drives the MD request handshake, then collects the MD response.
- Presents the collected result to writeback with a valid/ready handshake.
- Stalls the pipeline while the operation is outstanding, and handles pipeline kills by draining and discarding the in-flight response.

---
 rtl/raifes_md_issue_if.sv | 50 +++++
 rtl/raifes_md_issue.sv | 150 +++++++++++++++
 tb/tb_raifes_md_issue.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raifes_md_issue_if.sv
// Signal bundle between execute, the MD responder and writeback for raifes_md_issue.
// master: the issue controller; slave: the surrounding pipeline / MD unit.
interface raifes_md_issue_if #(
  parameter int unsigned XPR_LEN          = 32,
  parameter int unsigned MD_OP_WIDTH      = 2,
  parameter int unsigned MD_OUT_SEL_WIDTH = 2
);
  logic                        ex_md_valid;
  logic                        ex_kill;
  logic [MD_OP_WIDTH-1:0]      ex_md_op;
  logic [MD_OUT_SEL_WIDTH-1:0] ex_md_out_sel;
  logic                        ex_in_1_signed;
  logic                        ex_in_2_signed;
  logic [XPR_LEN-1:0]          ex_rs1;
  logic [XPR_LEN-1:0]          ex_rs2;
  logic [4:0]                  ex_rd;
  logic                        md_stall;

  logic                        req_valid;
  logic                        req_ready;
  logic [MD_OP_WIDTH-1:0]      req_op;
  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel;
  logic                        req_in_1_signed;
  logic                        req_in_2_signed;
  logic [XPR_LEN-1:0]          req_in_1;
  logic [XPR_LEN-1:0]          req_in_2;

  logic                        resp_valid;
  logic [XPR_LEN-1:0]          resp_result;

  logic                        wb_valid;
  logic                        wb_ready;
  logic [4:0]                  wb_rd;
  logic [XPR_LEN-1:0]          wb_data;
  logic                        md_err;

  modport master (
    input  ex_md_valid, ex_kill, ex_md_op, ex_md_out_sel, ex_in_1_signed, ex_in_2_signed,
           ex_rs1, ex_rs2, ex_rd, req_ready, resp_valid, resp_result, wb_ready,
    output md_stall, req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
           req_in_1, req_in_2, wb_valid, wb_rd, wb_data, md_err
  );

  modport slave (
    output ex_md_valid, ex_kill, ex_md_op, ex_md_out_sel, ex_in_1_signed, ex_in_2_signed,
           ex_rs1, ex_rs2, ex_rd, req_ready, resp_valid, resp_result, wb_ready,
    input  md_stall, req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
           req_in_1, req_in_2, wb_valid, wb_rd, wb_data, md_err
  );
endinterface

// File: rtl/raifes_md_issue.sv
// Requester-side MD issue controller: latches an execute-stage MUL/DIV/REM, runs the
// MD request/response handshake, hands the result to writeback and drains killed ops.
module raifes_md_issue #(
  parameter int unsigned TIMEOUT          = 64,
  parameter int unsigned TIMEOUT_W        = 8,
  parameter int unsigned XPR_LEN          = 32,
  parameter int unsigned MD_OP_WIDTH      = 2,
  parameter int unsigned MD_OUT_SEL_WIDTH = 2
) (
  input logic              clk,
  input logic              reset_n,
  raifes_md_issue_if.master md
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [2:0]                  state_q, state_d;
  logic [MD_OP_WIDTH-1:0]      op_q;
  logic [MD_OUT_SEL_WIDTH-1:0] sel_q;
  logic                        s1_q, s2_q;
  logic [XPR_LEN-1:0]          rs1_q, rs2_q, wb_data_q;
  logic [4:0]                  rd_q;
  logic [TIMEOUT_W-1:0]        wd_q;
  logic                        err_q;

  logic latch_c, capture_c, wd_clr_c, wd_inc_c, err_c, expired_c;
  logic stall_c, req_valid_c, wb_valid_c;

  assign expired_c = (wd_q == WD_LAST);

  // Next-state, handshake outputs and stall decode
  always_comb begin
    state_d     = state_q;
    latch_c     = 1'b0;
    capture_c   = 1'b0;
    wd_clr_c    = 1'b0;
    wd_inc_c    = 1'b0;
    err_c       = 1'b0;
    stall_c     = 1'b0;
    req_valid_c = 1'b0;
    wb_valid_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md.ex_md_valid && !md.ex_kill) begin
          latch_c = 1'b1;
          stall_c = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req_valid_c = 1'b1;
        stall_c     = 1'b1;
        if (md.req_ready) begin
          // a kill cannot retract an accepted transfer, so its response must be drained
          wd_clr_c = 1'b1;
          state_d  = md.ex_kill ? S_DRAIN : S_WAIT;
        end else if (md.ex_kill) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_c  = 1'b1;
        wd_inc_c = 1'b1;
        if (md.resp_valid) begin
          capture_c = !md.ex_kill;
          state_d   = md.ex_kill ? S_IDLE : S_WB;
        end else if (expired_c) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else if (md.ex_kill) begin
          wd_clr_c = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_c  = md.ex_md_valid;
        wd_inc_c = 1'b1;
        if (md.resp_valid) begin
          state_d = S_IDLE;
        end else if (expired_c) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        wb_valid_c = !md.ex_kill;
        stall_c    = !(md.wb_ready && !md.ex_kill);
        if (md.ex_kill || md.wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, instruction latches, result capture and watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      sel_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_c;
      if (latch_c) begin
        op_q  <= md.ex_md_op;
        sel_q <= md.ex_md_out_sel;
        s1_q  <= md.ex_in_1_signed;
        s2_q  <= md.ex_in_2_signed;
        rs1_q <= md.ex_rs1;
        rs2_q <= md.ex_rs2;
        rd_q  <= md.ex_rd;
      end
      if (capture_c) begin
        wb_data_q <= md.resp_result;
      end
      if (wd_clr_c) begin
        wd_q <= '0;
      end else if (wd_inc_c) begin
        wd_q <= wd_q + TIMEOUT_W'(1);
      end
    end
  end

  assign md.md_stall        = stall_c;
  assign md.req_valid       = req_valid_c;
  assign md.req_op          = op_q;
  assign md.req_out_sel     = sel_q;
  assign md.req_in_1_signed = s1_q;
  assign md.req_in_2_signed = s2_q;
  assign md.req_in_1        = rs1_q;
  assign md.req_in_2        = rs2_q;
  assign md.wb_valid        = wb_valid_c;
  assign md.wb_rd           = rd_q;
  assign md.wb_data         = wb_data_q;
  assign md.md_err          = err_q;
endmodule

// File: tb/tb_raifes_md_issue.sv
// Bench for raifes_md_issue: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model with an arithmetic MD responder.
module tb_raifes_md_issue;
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_REM = 2'd2;
  localparam logic [1:0] SEL_LO  = 2'd0;
  localparam logic [1:0] SEL_HI  = 2'd1;
  localparam logic [1:0] SEL_REM = 2'd2;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  raifes_md_issue_if bus ();
  raifes_md_issue #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (.clk(clk), .reset_n(reset_n), .md(bus));

  int checks = 0;
  int errors = 0;

  // transaction model
  bit          m_busy, m_issued, m_dead, m_has_res, m_err;
  int          m_wait;
  logic [1:0]  m_op, m_sel;
  logic        m_s1, m_s2;
  logic [31:0] m_a, m_b, m_exp;
  logic [4:0]  m_rd;
  bit          ex_adv;
  int          cyc, n_hs, n_wb, n_err, n_drained, n_req_hold, n_wb_hold, err_cyc;
  logic [31:0] last_wb_data;
  logic [4:0]  last_wb_rd;
  logic        last_wb_stall;

  // responder / stimulus controls
  bit          rnd, stray_en, rsp_never, rsp_pending;
  int          rdy_mode, rsp_lat, rsp_cnt;
  logic [31:0] rsp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] md_calc(input logic [1:0] op, input logic [1:0] sel,
                                          input logic s1, input logic s2,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb;
    ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    if (op == OP_MUL) return (sel == SEL_HI) ? p[63:32] : p[31:0];
    if (b == 32'h0) return (op == OP_DIV) ? 32'hFFFF_FFFF : a;
    if (s1) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == OP_DIV) ? a : 32'h0;
      return (op == OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
    end
    return (op == OP_DIV) ? a / b : a % b;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_dead = 0; m_has_res = 0; m_err = 0; m_wait = 0;
    rsp_pending = 0;
    ex_adv = 1;
  endtask

  task automatic set_ex(input logic [1:0] op, input logic [1:0] sel, input logic s1, input logic s2,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.ex_md_valid = 1'b1; bus.ex_md_op = op; bus.ex_md_out_sel = sel;
    bus.ex_in_1_signed = s1; bus.ex_in_2_signed = s2;
    bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_rd = rd;
  endtask

  // Random execute stage, MD responder and writeback back-pressure
  task automatic drive_inputs();
    logic [1:0] op;
    logic s;
    if (rnd) begin
      if (ex_adv) begin
        op = 2'($urandom_range(0, 2));
        s  = 1'($urandom);
        bus.ex_md_valid    = ($urandom_range(0, 3) != 0);
        bus.ex_md_op       = op;
        bus.ex_md_out_sel  = (op == OP_MUL) ? 2'($urandom_range(0, 1)) : ((op == OP_REM) ? SEL_REM : SEL_LO);
        bus.ex_in_1_signed = (op == OP_MUL) ? 1'($urandom) : s;
        bus.ex_in_2_signed = (op == OP_MUL) ? 1'($urandom) : s;
        bus.ex_rs1 = rand_opnd();
        bus.ex_rs2 = rand_opnd();
        bus.ex_rd  = 5'($urandom);
      end
      bus.ex_kill  = ($urandom_range(0, 23) == 0);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
    end
    case (rdy_mode)
      0:       bus.req_ready = 1'($urandom);
      1:       bus.req_ready = 1'b1;
      default: bus.req_ready = 1'b0;
    endcase
    bus.resp_valid  = 1'b0;
    bus.resp_result = 32'($urandom);
    if (rsp_pending) begin
      if (rsp_cnt <= 1) begin
        bus.resp_valid  = 1'b1;
        bus.resp_result = rsp_data;
        rsp_pending     = 0;
      end else begin
        rsp_cnt--;
      end
    end else if (stray_en && !(m_busy && m_issued && !m_has_res) && $urandom_range(0, 7) == 0) begin
      bus.resp_valid = 1'b1;
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  task automatic check_and_advance();
    bit v, k, wr, rr, rv, ph_idle, ph_req, ph_out, ph_wb, accept, e_stall, e_wbv;
    v = bus.ex_md_valid; k = bus.ex_kill; wr = bus.wb_ready; rr = bus.req_ready; rv = bus.resp_valid;
    ph_idle = !m_busy;
    ph_wb   = m_busy && m_has_res;
    ph_req  = m_busy && !m_issued;
    ph_out  = m_busy && m_issued && !m_has_res;
    accept  = ph_idle && v && !k;
    e_stall = accept || ph_req || (ph_out && !m_dead) || (ph_out && m_dead && v) || (ph_wb && !(wr && !k));
    e_wbv   = ph_wb && !k;

    chk("md_stall", 32'(bus.md_stall), 32'(e_stall));
    chk("req_valid", 32'(bus.req_valid), 32'(ph_req));
    chk("wb_valid", 32'(bus.wb_valid), 32'(e_wbv));
    chk("md_err", 32'(bus.md_err), 32'(m_err));
    if (ph_req) begin
      chk("req_op", 32'(bus.req_op), 32'(m_op));
      chk("req_out_sel", 32'(bus.req_out_sel), 32'(m_sel));
      chk("req_signs", 32'({bus.req_in_1_signed, bus.req_in_2_signed}), 32'({m_s1, m_s2}));
      chk("req_in_1", bus.req_in_1, m_a);
      chk("req_in_2", bus.req_in_2, m_b);
    end
    if (e_wbv) begin
      chk("wb_data", bus.wb_data, m_exp);
      chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
      if (wr) begin
        n_wb++;
        last_wb_data = bus.wb_data; last_wb_rd = bus.wb_rd; last_wb_stall = bus.md_stall;
      end
    end
    if (bus.md_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (bus.req_valid && !bus.req_ready) n_req_hold++;
    if (bus.wb_valid && !bus.wb_ready && bus.md_stall) n_wb_hold++;

    if (ph_req && rr && !rsp_never) begin
      rsp_pending = 1;
      rsp_cnt     = (rsp_lat == 0) ? $urandom_range(1, 35) : rsp_lat;
      rsp_data    = md_calc(bus.req_op, bus.req_out_sel, bus.req_in_1_signed, bus.req_in_2_signed,
                            bus.req_in_1, bus.req_in_2);
    end
    ex_adv = !e_stall || k;

    m_err = 0;
    if (ph_idle) begin
      if (accept) begin
        m_busy = 1; m_issued = 0; m_dead = 0; m_has_res = 0;
        m_op = bus.ex_md_op; m_sel = bus.ex_md_out_sel;
        m_s1 = bus.ex_in_1_signed; m_s2 = bus.ex_in_2_signed;
        m_a = bus.ex_rs1; m_b = bus.ex_rs2; m_rd = bus.ex_rd;
        m_exp = md_calc(m_op, m_sel, m_s1, m_s2, m_a, m_b);
      end
    end else if (ph_req) begin
      if (rr) begin
        m_issued = 1; m_dead = k; m_wait = 0; n_hs++;
      end else if (k) begin
        m_busy = 0;
      end
    end else if (ph_wb) begin
      if (k || wr) begin
        m_busy = 0; m_has_res = 0;
      end
    end else begin
      if (rv) begin
        if (m_dead) begin
          m_busy = 0; n_drained++;
        end else if (k) m_busy = 0;
        else m_has_res = 1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_err = 1; m_busy = 0;
      end else if (k && !m_dead) begin
        m_dead = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (ex_adv) done = 1'b1;
    end
    chk("op_completes", 32'(done), 32'd1);
    bus.ex_md_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0, wb0, e0, c0, d0, h0;
    bit got;
    rnd = 0; stray_en = 0; rsp_never = 0; rdy_mode = 1; rsp_lat = 4;
    cyc = 0; n_hs = 0; n_wb = 0; n_err = 0; n_drained = 0; n_req_hold = 0; n_wb_hold = 0; err_cyc = -1;
    reset_n = 1'b0;
    bus.ex_md_valid = 0; bus.ex_kill = 0; bus.ex_md_op = '0; bus.ex_md_out_sel = '0;
    bus.ex_in_1_signed = 0; bus.ex_in_2_signed = 0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
    bus.req_ready = 0; bus.resp_valid = 0; bus.resp_result = '0; bus.wb_ready = 1;
    model_reset();
    #12;
    chk("rst_md_stall", 32'(bus.md_stall), 32'd0);
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_md_err", 32'(bus.md_err), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_req_in_1", bus.req_in_1, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // signed MUL 7 * -3, low word
    hs0 = n_hs; wb0 = n_wb;
    set_ex(OP_MUL, SEL_LO, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd9);
    run_op(100);
    chk("mul_handshakes", 32'(n_hs - hs0), 32'd1);
    chk("mul_writebacks", 32'(n_wb - wb0), 32'd1);
    chk("mul_wb_data", last_wb_data, 32'hFFFF_FFEB);
    chk("mul_wb_rd", 32'(last_wb_rd), 32'd9);
    chk("mul_stall_in_wb", 32'(last_wb_stall), 32'd0);

    // req_ready withheld for 3 cycles, unsigned 100/7
    hs0 = n_hs; h0 = n_req_hold;
    rdy_mode = 2;
    set_ex(OP_DIV, SEL_LO, 1'b0, 1'b0, 32'd100, 32'd7, 5'd3);
    for (int i = 0; i < 4; i++) step();
    rdy_mode = 1;
    run_op(100);
    chk("hold_cycles", 32'(n_req_hold - h0), 32'd3);
    chk("hold_handshakes", 32'(n_hs - hs0), 32'd1);
    chk("divu_wb_data", last_wb_data, 32'd14);

    // kill 10 cycles into the wait, drain, then signed -20/3
    hs0 = n_hs; wb0 = n_wb; d0 = n_drained; rsp_lat = 30;
    set_ex(OP_DIV, SEL_LO, 1'b0, 1'b0, 32'd100, 32'd7, 5'd4);
    step(); step();
    for (int i = 0; i < 10; i++) step();
    bus.ex_kill = 1'b1;
    set_ex(OP_DIV, SEL_LO, 1'b1, 1'b1, 32'hFFFF_FFEC, 32'd3, 5'd6);
    step();
    bus.ex_kill = 1'b0;
    rsp_lat = 4;
    run_op(200);
    chk("kill_drained", 32'(n_drained - d0), 32'd1);
    chk("kill_writebacks", 32'(n_wb - wb0), 32'd1);
    chk("kill_handshakes", 32'(n_hs - hs0), 32'd2);
    chk("div_wb_data", last_wb_data, 32'hFFFF_FFFA);

    // writeback back-pressure for 5 cycles
    h0 = n_wb_hold; rsp_lat = 5; bus.wb_ready = 1'b0; got = 0;
    set_ex(OP_MUL, SEL_HI, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd17);
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (m_has_res) got = 1;
    end
    chk("bp_result_ready", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) step();
    bus.wb_ready = 1'b1;
    step();
    bus.ex_md_valid = 1'b0;
    chk("bp_hold_cycles", 32'(n_wb_hold - h0), 32'd5);
    chk("bp_release_stall", 32'(last_wb_stall), 32'd0);
    chk("bp_wb_data", last_wb_data, 32'd1);
    step();
    chk("bp_idle_req_valid", 32'(bus.req_valid), 32'd0);
    chk("bp_idle_wb_valid", 32'(bus.wb_valid), 32'd0);

    // responder never answers: watchdog abort
    rsp_never = 1; e0 = n_err; wb0 = n_wb;
    set_ex(OP_DIV, SEL_LO, 1'b0, 1'b0, 32'd50, 32'd5, 5'd2);
    step(); step();
    bus.ex_md_valid = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 70; i++) step();
    chk("wd_err_pulses", 32'(n_err - e0), 32'd1);
    chk("wd_err_cycle", 32'(err_cyc - c0), 32'd64);
    chk("wd_no_writeback", 32'(n_wb - wb0), 32'd0);
    rsp_never = 0;
    set_ex(OP_MUL, SEL_LO, 1'b0, 1'b0, 32'd3, 32'd4, 5'd8);
    run_op(100);
    chk("wd_next_wb_data", last_wb_data, 32'd12);

    // asynchronous reset mid-wait, then signed REM -7 % 2
    rsp_lat = 20;
    set_ex(OP_DIV, SEL_LO, 1'b0, 1'b0, 32'd99, 32'd9, 5'd5);
    for (int i = 0; i < 4; i++) step();
    bus.ex_md_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("arst_md_stall", 32'(bus.md_stall), 32'd0);
    chk("arst_wb_data", bus.wb_data, 32'd0);
    chk("arst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("arst_req_in_1", bus.req_in_1, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_lat = 4;
    set_ex(OP_REM, SEL_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd11);
    run_op(100);
    chk("rem_wb_data", last_wb_data, 32'hFFFF_FFFF);

    // random traffic with kills, stray responses and back-pressure
    wb0 = n_wb;
    rnd = 1; stray_en = 1; rdy_mode = 0; rsp_lat = 0; ex_adv = 1;
    for (int i = 0; i < 3000; i++) step();
    chk("random_made_progress", 32'(n_wb > wb0 + 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
